return_addr_stack: RTL and testbench
====================================

# return_addr_stack

Circular return-address stack beside the PC-update path. On a call (jump-and-link) it captures the return address, the call PC plus one instruction. On a return it supplies the saved address as the next-PC target. It is the counterpart to the jump-target adder: that adder computes where a jump goes, and this block records where execution resumes.

## Interface
Parameters:
- K, 32: PC / address width in bits.
- DEPTH, 8: number of entries; must be a power of two, at least 2.
- INSTR_BYTES, 4: byte increment from the call PC to the return address.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: asynchronous, active-low reset.
- flush, in, 1: synchronous clear of the stack and both sticky flags.
- push, in, 1: call retired this cycle.
- call_pc, in, K: PC of the call instruction; sampled when push=1.
- pop, in, 1: return retired this cycle.
- ret_pc, out, K: current top-of-stack return address.
- ret_valid, out, 1: 1 when the stack is non-empty (count>0).
- count, out, $clog2(DEPTH)+1: number of valid entries, 0..DEPTH.
- full, out, 1: count==DEPTH.
- overflow, out, 1: sticky; set when a push overwrites the oldest entry.
- underflow, out, 1: sticky; set when a pop occurs with count==0.

## Operation
- Storage: DEPTH registers of K bits, plus a top-of-stack pointer tos (log2 DEPTH bits) and count.
- Return address: call_pc + INSTR_BYTES, truncated to K bits, so 0xFFFFFFFC+4 gives 0x00000000. No carry out.
- Push only:
  - tos advances by 1 modulo DEPTH, then the return address is written to mem[new tos].
  - count increments, saturating at DEPTH.
  - If full: the oldest entry is silently overwritten, count stays DEPTH, overflow is set.
- Pop only:
  - If count>0: tos decrements modulo DEPTH and count decrements. Memory is unchanged.
  - If count==0: tos, count and memory hold, and underflow is set.
- Push and pop together (tail-call pattern):
  - If count>0: mem[tos] is replaced by the new return address. tos and count are unchanged. No flag is set.
  - If count==0: behaves as a push only (count becomes 1), and underflow is set.
- flush: count=0, tos=0, overflow=0, underflow=0. It has priority over push and pop in the same cycle. Memory contents are don't-care.
- ret_pc = mem[tos], always driven. Its value is meaningful only when ret_valid=1. Verification must not check ret_pc while ret_valid=0.
- Reset (rst_n=0, asynchronous):
  - tos=0, count=0, ret_valid=0, full=0, overflow=0, underflow=0.
  - All memory entries are cleared to 0, so ret_pc reads 0 in reset.
  - Deasserting rst_n mid-operation discards all stacked entries.

## Timing
- Every update takes effect at the clk edge that samples push, pop or flush. Outputs reflect the new state in the cycle after that edge (one-cycle latency).
- ret_pc, ret_valid, count and full are decoded from registered state only, with no combinational path from push, pop or flush.
- Back-to-back operations are legal every cycle; there is no stall and no ready handshake.
- overflow and underflow go high one cycle after the offending edge. They stay high until flush or reset.

## Structure
- The shared package holds:
  - default values for K, DEPTH and INSTR_BYTES;
  - a width function for count and tos;
  - a typedef for the K-bit pc_t, shared with the PC-update datapath.
- One sub-module, ras_mem: DEPTH×K register file with one write port and one asynchronous read port, reset to zero.
- Pointer, count and flag logic live in return_addr_stack.

## Test plan
All cases use the default parameters.
1. Reset, then push call_pc=0x100 -> next cycle ret_pc=0x104, ret_valid=1, count=1. Pop -> count=0, ret_valid=0.
2. Push 0x10, 0x20, 0x30, then pop three times -> ret_pc reads 0x34, 0x24, 0x14 in turn. Then count=0, underflow=0.
3. Push 9 times with call_pc = 0x0, 0x10, …, 0x80 -> full=1, count=8, overflow=1. Eight pops yield 0x84 down to 0x14. The 0x04 entry is lost.
4. Pop at count=0 -> underflow=1, count=0. Then simultaneous push (call_pc=0x200) and pop at count=0 -> count=1, ret_pc=0x204.
5. With count=2 and top=0x54, simultaneous push (call_pc=0x70) and pop -> count=2, ret_pc=0x74. Then one pop -> ret_pc equals the previous second entry.
6. Edge cases:
   - call_pc=0xFFFFFFFC -> ret_pc=0x00000000.
   - flush asserted with push=1 -> count=0, flags=0.
   - rst_n low mid-sequence -> all outputs return to their reset values immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/return_addr_stack_pkg.sv
// Shared types and sizing helpers for the return-address stack and the PC-update datapath.
package return_addr_stack_pkg;

  localparam int K_DEF           = 32;
  localparam int DEPTH_DEF       = 8;
  localparam int INSTR_BYTES_DEF = 4;

  typedef logic [K_DEF-1:0] pc_t;

  // Width of the top-of-stack pointer.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  // Width of the occupancy count, which must also represent the value DEPTH.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/return_addr_stack_if.sv
// Retire-side connection to the return-address stack: call/return strobes in, top-of-stack and status out.
interface return_addr_stack_if
  import return_addr_stack_pkg::*;
#(
  parameter int K     = K_DEF,
  parameter int DEPTH = DEPTH_DEF
) ();

  // push/pop/flush are single-cycle strobes with no ready: every asserted cycle is
  // consumed at that rising edge, and results appear on the outputs the cycle after.
  logic                     flush;
  logic                     push;
  logic                     pop;
  logic [K-1:0]             call_pc;
  logic [K-1:0]             ret_pc;
  logic                     ret_valid;
  logic [cnt_w(DEPTH)-1:0]  count;
  logic                     full;
  logic                     overflow;
  logic                     underflow;

  modport master (
    output flush, push, pop, call_pc,
    input  ret_pc, ret_valid, count, full, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, call_pc,
    output ret_pc, ret_valid, count, full, overflow, underflow
  );

endinterface

// File: rtl/return_addr_stack_ras_mem.sv
// DEPTH x K register file: one write port, one asynchronous read port, cleared on reset.
module ras_mem #(
  parameter int K     = 32,
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [K-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [K-1:0]  rdata
);

  logic [K-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/return_addr_stack.sv
// Circular return-address stack: records call_pc + INSTR_BYTES on calls, supplies it on returns.
module return_addr_stack
  import return_addr_stack_pkg::*;
#(
  parameter int K           = K_DEF,
  parameter int DEPTH       = DEPTH_DEF,
  parameter int INSTR_BYTES = INSTR_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  return_addr_stack_if.slave bus
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0] tos, tos_nxt, waddr;
  logic [CW-1:0] count, count_nxt;
  logic          we, set_ovf, set_unf;
  logic          overflow_q, underflow_q;
  logic          empty, at_max;
  logic [K-1:0]  ret_addr;

  assign empty    = (count == '0);
  assign at_max   = (count == CNT_MAX);
  assign ret_addr = bus.call_pc + K'(INSTR_BYTES);

  always_comb begin
    tos_nxt   = tos;
    count_nxt = count;
    waddr     = tos;
    we        = 1'b0;
    set_ovf   = 1'b0;
    set_unf   = 1'b0;
    if (bus.push && bus.pop) begin
      we = 1'b1;
      // Tail call on an empty stack degrades to a plain push but still flags the bad pop.
      if (empty) begin
        tos_nxt   = tos + PTR_ONE;
        waddr     = tos + PTR_ONE;
        count_nxt = CNT_ONE;
        set_unf   = 1'b1;
      end
    end else if (bus.push) begin
      we      = 1'b1;
      tos_nxt = tos + PTR_ONE;
      waddr   = tos + PTR_ONE;
      if (at_max) set_ovf = 1'b1;
      else        count_nxt = count + CNT_ONE;
    end else if (bus.pop) begin
      if (empty) begin
        set_unf = 1'b1;
      end else begin
        tos_nxt   = tos - PTR_ONE;
        count_nxt = count - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tos         <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      tos         <= '0;
      count       <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      tos         <= tos_nxt;
      count       <= count_nxt;
      overflow_q  <= overflow_q | set_ovf;
      underflow_q <= underflow_q | set_unf;
    end
  end

  ras_mem #(.K(K), .DEPTH(DEPTH), .AW(PW)) u_mem (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (we && !bus.flush),
    .waddr (waddr),
    .wdata (ret_addr),
    .raddr (tos),
    .rdata (bus.ret_pc)
  );

  assign bus.ret_valid = !empty;
  assign bus.count     = count;
  assign bus.full      = at_max;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_return_addr_stack.sv
// Self-checking bench for return_addr_stack against a queue-based stack model.
module tb_return_addr_stack;
  import return_addr_stack_pkg::*;

  localparam int DEPTH = DEPTH_DEF;
  localparam int CW    = cnt_w(DEPTH);

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  // Model: exp_q[$] is the stack, newest entry at the back.
  logic [K_DEF-1:0] exp_q[$];
  logic             exp_ovf;
  logic             exp_unf;

  return_addr_stack_if bus ();

  return_addr_stack dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    exp_q.delete();
    exp_ovf = 1'b0;
    exp_unf = 1'b0;
  endtask

  task automatic model_update(input logic p, input logic q, input logic f, input pc_t pc);
    pc_t ra;
    ra = pc + pc_t'(INSTR_BYTES_DEF);
    if (f) begin
      model_clear();
    end else if (p && q) begin
      if (exp_q.size() == 0) begin
        exp_q.push_back(ra);
        exp_unf = 1'b1;
      end else begin
        exp_q[exp_q.size()-1] = ra;
      end
    end else if (p) begin
      exp_q.push_back(ra);
      if (exp_q.size() > DEPTH) begin
        void'(exp_q.pop_front());
        exp_ovf = 1'b1;
      end
    end else if (q) begin
      if (exp_q.size() == 0) exp_unf = 1'b1;
      else void'(exp_q.pop_back());
    end
  endtask

  // Drives one cycle of stimulus and leaves the bench #1 after the sampling edge.
  task automatic apply_op(input logic p, input logic q, input logic f, input pc_t pc);
    bus.push    = p;
    bus.pop     = q;
    bus.flush   = f;
    bus.call_pc = pc;
    @(posedge clk);
    #1;
    bus.push  = 1'b0;
    bus.pop   = 1'b0;
    bus.flush = 1'b0;
    model_update(p, q, f, pc);
  endtask

  task automatic test_reset();
    checks += 6;
    if (bus.count !== '0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.ret_valid); end
    if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL reset_unf got %b want 0", bus.underflow); end
    if (bus.ret_pc !== '0) begin errors++; $display("FAIL reset_ret_pc got %h want 0", bus.ret_pc); end
  endtask

  task automatic test_basic();
    apply_op(1'b1, 1'b0, 1'b0, 32'h100);
    checks += 3;
    if (bus.ret_pc !== 32'h104) begin errors++; $display("FAIL basic_ret_pc got %h want 104", bus.ret_pc); end
    if (bus.ret_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b want 1", bus.ret_valid); end
    if (bus.count !== CW'(1)) begin errors++; $display("FAIL basic_count got %0d want 1", bus.count); end
    apply_op(1'b0, 1'b1, 1'b0, '0);
    checks += 2;
    if (bus.count !== '0) begin errors++; $display("FAIL basic_pop_count got %0d want 0", bus.count); end
    if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %b want 0", bus.ret_valid); end
  endtask

  task automatic test_lifo();
    pc_t want;
    apply_op(1'b1, 1'b0, 1'b0, 32'h10);
    apply_op(1'b1, 1'b0, 1'b0, 32'h20);
    apply_op(1'b1, 1'b0, 1'b0, 32'h30);
    for (int i = 0; i < 3; i++) begin
      want = 32'h34 - pc_t'(i * 16);
      checks++;
      if (bus.ret_pc !== want) begin errors++; $display("FAIL lifo_ret_pc[%0d] got %h want %h", i, bus.ret_pc, want); end
      apply_op(1'b0, 1'b1, 1'b0, '0);
    end
    checks += 2;
    if (bus.count !== '0) begin errors++; $display("FAIL lifo_count got %0d want 0", bus.count); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL lifo_unf got %b want 0", bus.underflow); end
  endtask

  task automatic test_overflow();
    pc_t want;
    for (int i = 0; i < 9; i++) apply_op(1'b1, 1'b0, 1'b0, pc_t'(i * 16));
    checks += 3;
    if (bus.full !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.full); end
    if (bus.count !== CW'(8)) begin errors++; $display("FAIL ovf_count got %0d want 8", bus.count); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow); end
    for (int i = 0; i < 8; i++) begin
      want = 32'h84 - pc_t'(i * 16);
      checks++;
      if (bus.ret_pc !== want) begin errors++; $display("FAIL ovf_ret_pc[%0d] got %h want %h", i, bus.ret_pc, want); end
      apply_op(1'b0, 1'b1, 1'b0, '0);
    end
    checks += 2;
    if (bus.count !== '0) begin errors++; $display("FAIL ovf_drain_count got %0d want 0", bus.count); end
    if (bus.overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", bus.overflow); end
  endtask

  task automatic test_underflow();
    apply_op(1'b0, 1'b1, 1'b0, '0);
    checks += 2;
    if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_flag got %b want 1", bus.underflow); end
    if (bus.count !== '0) begin errors++; $display("FAIL unf_count got %0d want 0", bus.count); end
    apply_op(1'b1, 1'b1, 1'b0, 32'h200);
    checks += 3;
    if (bus.count !== CW'(1)) begin errors++; $display("FAIL unf_tail_count got %0d want 1", bus.count); end
    if (bus.ret_pc !== 32'h204) begin errors++; $display("FAIL unf_tail_ret_pc got %h want 204", bus.ret_pc); end
    if (bus.underflow !== 1'b1) begin errors++; $display("FAIL unf_tail_flag got %b want 1", bus.underflow); end
  endtask

  task automatic test_tail_call();
    apply_op(1'b0, 1'b0, 1'b1, '0);
    checks += 3;
    if (bus.count !== '0) begin errors++; $display("FAIL flush_count got %0d want 0", bus.count); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL flush_ovf got %b want 0", bus.overflow); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL flush_unf got %b want 0", bus.underflow); end
    apply_op(1'b1, 1'b0, 1'b0, 32'h40);
    apply_op(1'b1, 1'b0, 1'b0, 32'h50);
    checks++;
    if (bus.ret_pc !== 32'h54) begin errors++; $display("FAIL tail_pre_top got %h want 54", bus.ret_pc); end
    apply_op(1'b1, 1'b1, 1'b0, 32'h70);
    checks += 3;
    if (bus.count !== CW'(2)) begin errors++; $display("FAIL tail_count got %0d want 2", bus.count); end
    if (bus.ret_pc !== 32'h74) begin errors++; $display("FAIL tail_ret_pc got %h want 74", bus.ret_pc); end
    if (bus.underflow !== 1'b0 || bus.overflow !== 1'b0) begin
      errors++; $display("FAIL tail_flags got ovf=%b unf=%b want 0 0", bus.overflow, bus.underflow);
    end
    apply_op(1'b0, 1'b1, 1'b0, '0);
    checks += 2;
    if (bus.ret_pc !== 32'h44) begin errors++; $display("FAIL tail_second got %h want 44", bus.ret_pc); end
    if (bus.count !== CW'(1)) begin errors++; $display("FAIL tail_pop_count got %0d want 1", bus.count); end
  endtask

  task automatic test_edges();
    apply_op(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC);
    checks++;
    if (bus.ret_pc !== 32'h0) begin errors++; $display("FAIL wrap_ret_pc got %h want 0", bus.ret_pc); end
    apply_op(1'b0, 1'b1, 1'b0, '0);
    apply_op(1'b0, 1'b1, 1'b0, '0);
    apply_op(1'b0, 1'b1, 1'b0, '0);
    checks++;
    if (bus.underflow !== 1'b1) begin errors++; $display("FAIL edge_unf_set got %b want 1", bus.underflow); end
    apply_op(1'b1, 1'b0, 1'b1, 32'h300);
    checks += 4;
    if (bus.count !== '0) begin errors++; $display("FAIL flush_push_count got %0d want 0", bus.count); end
    if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL flush_push_valid got %b want 0", bus.ret_valid); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL flush_push_unf got %b want 0", bus.underflow); end
    if (bus.overflow !== 1'b0) begin errors++; $display("FAIL flush_push_ovf got %b want 0", bus.overflow); end
  endtask

  task automatic test_async_reset();
    apply_op(1'b0, 1'b1, 1'b0, '0);
    apply_op(1'b1, 1'b0, 1'b0, 32'h400);
    apply_op(1'b1, 1'b0, 1'b0, 32'h500);
    #2;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.count !== '0) begin errors++; $display("FAIL areset_count got %0d want 0", bus.count); end
    if (bus.ret_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", bus.ret_valid); end
    if (bus.ret_pc !== '0) begin errors++; $display("FAIL areset_ret_pc got %h want 0", bus.ret_pc); end
    if (bus.underflow !== 1'b0) begin errors++; $display("FAIL areset_unf got %b want 0", bus.underflow); end
    if (bus.full !== 1'b0) begin errors++; $display("FAIL areset_full got %b want 0", bus.full); end
    #2;
    rst_n = 1'b1;
    model_clear();
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic p, q, f;
    pc_t  pc;
    for (int n = 0; n < 400; n++) begin
      p  = ($urandom_range(0, 99) < 55);
      q  = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 39) == 0);
      pc = pc_t'($urandom);
      apply_op(p, q, f, pc);
      checks += 5;
      if (bus.count !== CW'(exp_q.size())) begin errors++; $display("FAIL rand_count[%0d] got %0d want %0d", n, bus.count, exp_q.size()); end
      if (bus.ret_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rand_valid[%0d] got %b", n, bus.ret_valid); end
      if (bus.full !== (exp_q.size() == DEPTH)) begin errors++; $display("FAIL rand_full[%0d] got %b", n, bus.full); end
      if (bus.overflow !== exp_ovf) begin errors++; $display("FAIL rand_ovf[%0d] got %b want %b", n, bus.overflow, exp_ovf); end
      if (bus.underflow !== exp_unf) begin errors++; $display("FAIL rand_unf[%0d] got %b want %b", n, bus.underflow, exp_unf); end
      if (exp_q.size() != 0) begin
        checks++;
        if (bus.ret_pc !== exp_q[exp_q.size()-1]) begin
          errors++; $display("FAIL rand_ret_pc[%0d] got %h want %h", n, bus.ret_pc, exp_q[exp_q.size()-1]);
        end
      end
    end
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst_n       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.flush   = 1'b0;
    bus.call_pc = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic();
    test_lifo();
    test_overflow();
    test_underflow();
    test_tail_call();
    test_edges();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
